// File: rtl/shift_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROL) that applies one power-of-two stage per cycle.
// Result latency is fixed at SHAMT_W cycles after accept, independent of shamt.
//
// state | meaning
// IDLE  | waiting for start; result held
// SHIFT | stage k applies 2^k when latched shamt bit k is set
// DONE  | one-cycle done pulse, result valid
module shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               result_zero
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);
  localparam logic [SHAMT_W:0]   W_FULL = (SHAMT_W + 1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SHAMT_W-1:0] k;
  logic [SHAMT_W-1:0] sh_bits;
  logic [SHAMT_W-1:0] amt;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   work_nxt;

  // sh_bits shifts right each stage so bit 0 is always the current stage's enable;
  // amt doubles each stage so it always equals 2^k.
  always_comb begin
    shifted = work;
    case (mode_q)
      MODE_SLL: shifted = work << amt;
      MODE_SRL: shifted = work >> amt;
      MODE_SRA: shifted = $unsigned($signed(work) >>> amt);
      MODE_ROL: shifted = (work << amt) | (work >> (W_FULL - {1'b0, amt}));
      default:  shifted = work;
    endcase
    work_nxt = sh_bits[0] ? shifted : work;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k           <= '0;
      sh_bits     <= '0;
      amt         <= '0;
      mode_q      <= MODE_SLL;
      work        <= '0;
      result      <= '0;
      result_zero <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work    <= data_in;
            sh_bits <= shamt;
            mode_q  <= mode;
            k       <= '0;
            amt     <= SHAMT_W'(1);
          end
        end
        SHIFT: begin
          work    <= work_nxt;
          sh_bits <= sh_bits >> 1;
          amt     <= amt << 1;
          k       <= k + SHAMT_W'(1);
          if (k == K_LAST) begin
            result      <= work_nxt;
            result_zero <= (work_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed vectors, randomized ops against a
// bit-level reference model, handshake behaviour, and an 8-bit instance.
module tb_shift_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        result_zero;

  logic        s8_start;
  logic [7:0]  s8_data_in;
  logic [2:0]  s8_shamt;
  logic [1:0]  s8_mode;
  logic        s8_busy;
  logic        s8_done;
  logic [7:0]  s8_result;
  logic        s8_result_zero;

  int total = 0;
  int bad   = 0;

  shift_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .shamt(shamt), .mode(mode), .busy(busy), .done(done),
    .result(result), .result_zero(result_zero)
  );

  shift_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(s8_start), .data_in(s8_data_in),
    .shamt(s8_shamt), .mode(s8_mode), .busy(s8_busy), .done(s8_done),
    .result(s8_result), .result_zero(s8_result_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-level reference: output bit i is picked straight from the source bit it came from.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d,
                                        input int sh, input int w);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'd0:    o[i] = (i >= sh) ? d[i-sh] : 1'b0;
        2'd1:    o[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        2'd2:    o[i] = (i + sh < w) ? d[i+sh] : d[w-1];
        default: o[i] = d[(i - sh + w) % w];
      endcase
    end
    return o;
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [31:0] d, input logic [4:0] sh,
                        output logic [31:0] res, output logic rz, output int lat,
                        output logic busy_acc);
    @(negedge clk);
    start = 1'b1; mode = m; data_in = d; shamt = sh;
    @(posedge clk);
    #1 busy_acc = busy;
    @(negedge clk);
    start = 1'b0;
    data_in = $urandom;
    shamt = 5'($urandom_range(31));
    mode = 2'($urandom_range(3));
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    res = result;
    rz  = result_zero;
    @(posedge clk);
  endtask

  task automatic run_op8(input logic [1:0] m, input logic [7:0] d, input logic [2:0] sh,
                         output logic [7:0] res, output int lat);
    @(negedge clk);
    s8_start = 1'b1; s8_mode = m; s8_data_in = d; s8_shamt = sh;
    @(posedge clk);
    @(negedge clk);
    s8_start = 1'b0; s8_data_in = 8'($urandom_range(255));
    lat = 0;
    while (s8_done !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    res = s8_result;
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] res; logic rz; int lat; logic ba; int n_done;
    reset_n = 1'b0; start = 1'b0; data_in = '0; shamt = '0; mode = '0;
    s8_start = 1'b0; s8_data_in = '0; s8_shamt = '0; s8_mode = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (result_zero !== 1'b1) begin bad++; $display("FAIL reset_rz got=%b exp=1", result_zero); end
    reset_n = 1'b1;
    run_op(2'd0, 32'hFFFF_FFFF, 5'd2, res, rz, lat, ba);
    // second op aborted by reset mid-SHIFT
    @(negedge clk);
    start = 1'b1; mode = 2'd0; data_in = 32'hA5A5_0001; shamt = 5'd31;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL abort_result got=%h exp=0", result); end
    total++; if (result_zero !== 1'b1) begin bad++; $display("FAIL abort_rz got=%b exp=1", result_zero); end
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) reset_n = 1'b1;
      if (done === 1'b1) n_done++;
    end
    total++; if (n_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL abort_result_hold got=%h exp=0", result); end
    // start on the very first edge after reset release
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; start = 1'b1; mode = 2'd0; data_in = 32'h1; shamt = 5'd0;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_edge_accept got=%b exp=1", busy); end
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL post_reset_lat got=%0d exp=5", lat); end
    total++; if (result !== 32'h1) begin bad++; $display("FAIL post_reset_result got=%h exp=1", result); end
    @(posedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  tm[10]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd3};
    logic [31:0] td[10]  = '{32'hFFFF_FFFF, 32'h0, 32'hCD6A_A5AD, 32'h8000_0000, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'h8000_0001, 32'h1234_5678, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [4:0]  ts[10]  = '{5'd2, 5'd2, 5'd2, 5'd31, 5'd31, 5'd4, 5'd1, 5'd16, 5'd1, 5'd0};
    logic [31:0] te[10]  = '{32'hFFFF_FFFC, 32'h0, 32'h35AA_96B4, 32'h1, 32'hFFFF_FFFF,
                             32'h07FF_FFFF, 32'h3, 32'h5678_1234, 32'h0, 32'hDEAD_BEEF};
    logic [31:0] res; logic rz; int lat; logic ba;
    for (int i = 0; i < 10; i++) begin
      run_op(tm[i], td[i], ts[i], res, rz, lat, ba);
      total++; if (res !== te[i]) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, te[i]); end
      total++; if (rz !== (te[i] == 32'h0)) begin bad++; $display("FAIL dir%0d_rz got=%b exp=%b", i, rz, te[i] == 32'h0); end
      total++; if (lat !== 5) begin bad++; $display("FAIL dir%0d_lat got=%0d exp=5", i, lat); end
      total++; if (ba !== 1'b1) begin bad++; $display("FAIL dir%0d_busy_at_accept got=%b exp=1", i, ba); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dir_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    logic [31:0] res, d, exp; logic rz; int lat; logic ba; logic [1:0] m; logic [4:0] sh;
    for (int i = 0; i < 40; i++) begin
      m  = 2'($urandom_range(3));
      sh = 5'($urandom_range(31));
      d  = (i % 8 == 7) ? 32'h0 : $urandom;
      exp = model(m, d, int'(sh), 32);
      run_op(m, d, sh, res, rz, lat, ba);
      total++; if (res !== exp) begin bad++; $display("FAIL rnd%0d_result mode=%0d sh=%0d d=%h got=%h exp=%h", i, m, sh, d, res, exp); end
      total++; if (rz !== (exp == 32'h0)) begin bad++; $display("FAIL rnd%0d_rz got=%b exp=%b", i, rz, exp == 32'h0); end
      total++; if (lat !== 5) begin bad++; $display("FAIL rnd%0d_lat got=%0d exp=5", i, lat); end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, n_done, done_cyc;
    logic [31:0] res_at_done;
    @(negedge clk);
    start = 1'b1; mode = 2'd0; data_in = 32'h1234_5678; shamt = 5'd4;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; mode = 2'd1; data_in = 32'hDEAD_BEEF; shamt = 5'd3;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    cyc = 2; n_done = 0; done_cyc = -1; res_at_done = '0;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = cyc; res_at_done = result; end
      end
      @(posedge clk); cyc++; @(negedge clk);
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
    total++; if (done_cyc !== 5) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=5", done_cyc); end
    total++; if (res_at_done !== 32'h2345_6780) begin bad++; $display("FAIL ignore_result got=%h exp=23456780", res_at_done); end
    total++; if (result !== 32'h2345_6780) begin bad++; $display("FAIL ignore_result_held got=%h exp=23456780", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, n_acc, n_done, budget;
    int acc[2];
    logic prev_busy;
    logic [31:0] d, exp;
    logic [4:0] sh;
    logic res_ok;
    d = $urandom; sh = 5'($urandom_range(31));
    exp = model(2'd2, d, int'(sh), 32);
    @(negedge clk);
    prev_busy = busy;
    start = 1'b1; mode = 2'd2; data_in = d; shamt = sh;
    cyc = 0; n_acc = 0; n_done = 0; res_ok = 1'b1; acc[0] = 0; acc[1] = 0;
    budget = 0;
    while (n_done < 2 && budget < 40) begin
      @(posedge clk); cyc++; budget++; @(negedge clk);
      if (busy === 1'b1 && prev_busy === 1'b0) begin
        if (n_acc < 2) acc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 2) start = 1'b0;
      end
      if (done === 1'b1) begin
        n_done++;
        if (result !== exp) res_ok = 1'b0;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    total++; if (n_acc !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", n_acc); end
    total++; if (acc[1] - acc[0] !== 7) begin bad++; $display("FAIL b2b_interval got=%0d exp=7", acc[1] - acc[0]); end
    total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    total++; if (res_ok !== 1'b1) begin bad++; $display("FAIL b2b_result got=%h exp=%h", result, exp); end
    budget = 0;
    while (busy !== 1'b0 && budget < 20) begin @(negedge clk); budget++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_return_idle got=%b exp=0", busy); end
  endtask

  task automatic test_width8();
    logic [7:0] res, d, exp; int lat; logic [1:0] m; logic [2:0] sh;
    run_op8(2'd2, 8'h90, 3'd3, res, lat);
    total++; if (res !== 8'hF2) begin bad++; $display("FAIL w8_sra_result got=%h exp=f2", res); end
    total++; if (lat !== 3) begin bad++; $display("FAIL w8_sra_lat got=%0d exp=3", lat); end
    for (int i = 0; i < 12; i++) begin
      m  = 2'($urandom_range(3));
      sh = 3'($urandom_range(7));
      d  = 8'($urandom_range(255));
      exp = 8'(model(m, {24'h0, d}, int'(sh), 8));
      run_op8(m, d, sh, res, lat);
      total++; if (res !== exp) begin bad++; $display("FAIL w8_rnd%0d mode=%0d sh=%0d d=%h got=%h exp=%h", i, m, sh, d, res, exp); end
      total++; if (lat !== 3) begin bad++; $display("FAIL w8_rnd%0d_lat got=%0d exp=3", i, lat); end
    end
    total++; if (s8_result_zero !== (s8_result == 8'h0)) begin bad++; $display("FAIL w8_rz got=%b exp=%b", s8_result_zero, s8_result == 8'h0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
